// File: rtl/tx_frame_controller.sv
// rtl/tx_frame_controller.sv - USART transmit frame sequencer (start, 5-9 data, parity, 1-2 stop bits)
// Optional line-break hold is compiled in with `define USART_TX_BREAK_EN.
module tx_frame_controller #(
    parameter int BITCNT_W = 4
) (
    input  logic       i_fosk,
    input  logic       i_rst,
    input  logic       i_txclk,
    input  logic       i_TXEN,
    input  logic       i_udre,
    input  logic [2:0] i_UCSZ,
    input  logic       i_UPM1,
    input  logic       i_USBS,
    input  logic       i_txc_clr,
`ifdef USART_TX_BREAK_EN
    input  logic       i_brk,
`endif
    output logic       o_fsm_we,
    output logic       o_fsm_ps,
    output logic       o_fsm_ad,
    output logic       o_fsm_pi,
    output logic       o_fsm_dp,
    output logic       o_txc,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t              state_q, state_d;
    logic [BITCNT_W-1:0] cnt_q, cnt_d;
    logic [BITCNT_W-1:0] size_q, size_d;
    logic                par_en_q, par_en_d;
    logic                two_stop_q, two_stop_d;
    logic                txc_q, txc_d;
    logic                busy_q, busy_d;

    logic start;
    logic line_hold;
    logic load;
    logic eof;

    function automatic logic [BITCNT_W-1:0] char_size(input logic [2:0] ucsz);
        case (ucsz)
            3'b000:  char_size = BITCNT_W'(5);
            3'b001:  char_size = BITCNT_W'(6);
            3'b010:  char_size = BITCNT_W'(7);
            3'b111:  char_size = BITCNT_W'(9);
            default: char_size = BITCNT_W'(8);
        endcase
    endfunction

`ifdef USART_TX_BREAK_EN
    // brk_q remembers that the previous tick was a break tick, so the
    // released line shows a full idle bit before the next start bit.
    logic brk_q, brk_d;

    always_comb begin
        brk_d = brk_q;
        if (i_txclk) begin
            brk_d = (state_q == S_IDLE) & i_brk;
        end
    end

    always_ff @(posedge i_fosk) begin
        if (i_rst) begin
            brk_q <= 1'b0;
        end else begin
            brk_q <= brk_d;
        end
    end

    assign line_hold = i_brk;
    assign start     = i_TXEN & ~i_udre & ~i_brk & ~brk_q;
`else
    assign line_hold = 1'b0;
    assign start     = i_TXEN & ~i_udre;
`endif

    assign load = i_txclk & (state_q == S_IDLE) & start;

    always_ff @(posedge i_fosk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            size_q     <= BITCNT_W'(8);
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            txc_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            txc_q      <= txc_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        eof        = 1'b0;
        if (i_txclk) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        size_d     = char_size(i_UCSZ);
                        par_en_d   = i_UPM1;
                        two_stop_d = i_USBS;
                        cnt_d      = '0;
                        state_d    = S_DATA;
                    end
                end
                S_DATA: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == size_q - 1'b1) begin
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                    end
                end
                S_PARITY: state_d = S_STOP1;
                S_STOP1: begin
                    if (two_stop_q) begin
                        state_d = S_STOP2;
                    end else begin
                        state_d = S_IDLE;
                        eof     = 1'b1;
                    end
                end
                S_STOP2: begin
                    state_d = S_IDLE;
                    eof     = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Set is evaluated last so a completing frame beats a coincident clear.
    always_comb begin
        txc_d = txc_q;
        if (i_txc_clr | load) begin
            txc_d = 1'b0;
        end
        if (eof & i_udre) begin
            txc_d = 1'b1;
        end
        busy_d = (state_d != S_IDLE) | line_hold;
    end

    always_comb begin
        o_fsm_we = 1'b0;
        o_fsm_ps = 1'b1;
        o_fsm_ad = 1'b0;
        o_fsm_pi = 1'b1;
        o_fsm_dp = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_fsm_we = start;
                o_fsm_ps = ~start & ~line_hold;
            end
            S_DATA: begin
                o_fsm_ad = 1'b1;
                o_fsm_pi = 1'b0;
            end
            S_PARITY: begin
                o_fsm_dp = 1'b1;
                o_fsm_pi = 1'b0;
            end
            default: ;
        endcase
    end

    assign o_txc  = txc_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_tx_frame_controller.sv
// tb/tb_tx_frame_controller.sv - self-checking bench for tx_frame_controller
module tb_tx_frame_controller;

    logic       clk = 1'b0;
    logic       rst, txclk, txen, udre, upm1, usbs, txc_clr;
    logic [2:0] ucsz;
`ifdef USART_TX_BREAK_EN
    logic       brk;
`endif
    logic       we, ps, ad, pi, dp, txc, busy;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    // Minimal transmit data path: UDR, shift register, parity and TxD flop.
    logic [8:0] udr, shreg;
    logic       par, upm0, txd;

    logic exp_q[$];

    always #5 clk = ~clk;

    tx_frame_controller #(.BITCNT_W(4)) dut (
        .i_fosk   (clk),
        .i_rst    (rst),
        .i_txclk  (txclk),
        .i_TXEN   (txen),
        .i_udre   (udre),
        .i_UCSZ   (ucsz),
        .i_UPM1   (upm1),
        .i_USBS   (usbs),
        .i_txc_clr(txc_clr),
`ifdef USART_TX_BREAK_EN
        .i_brk    (brk),
`endif
        .o_fsm_we (we),
        .o_fsm_ps (ps),
        .o_fsm_ad (ad),
        .o_fsm_pi (pi),
        .o_fsm_dp (dp),
        .o_txc    (txc),
        .o_busy   (busy)
    );

    typedef struct {
        logic [2:0]  ucsz;
        logic        upm1;
        logic        upm0;
        logic        usbs;
        logic [8:0]  data;
        int          len;
        logic [11:0] bits;   // first line bit is bits[len-1]
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic clr);
        logic c_we, c_ps, c_ad, c_dp, c_pi;
        txclk   = 1'b1;
        txc_clr = clr;
        #1;
        c_we = we; c_ps = ps; c_ad = ad; c_dp = dp; c_pi = pi;
        @(posedge clk); #1;
        txclk   = 1'b0;
        txc_clr = 1'b0;
        if (c_we) begin
            shreg = udr;
            udre  = 1'b1;
            we_cnt++;
        end
        if (c_ad) begin
            txd   = shreg[0];
            par   = par ^ shreg[0];
            shreg = shreg >> 1;
        end else if (c_dp) begin
            txd = par ^ upm0;
        end else begin
            txd = c_ps;
        end
        if (c_pi) par = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic write_udr(input logic [8:0] d);
        udr  = d;
        udre = 1'b0;
    endtask

    // Reference frame built straight from the line format rules.
    task automatic push_frame(input logic [2:0] f_ucsz, input logic f_upm1, input logic f_upm0,
                              input logic f_usbs, input logic [8:0] d);
        int  n;
        logic p;
        n = (f_ucsz == 3'd7) ? 9 : (f_ucsz < 3'd4) ? int'(f_ucsz) + 5 : 8;
        p = f_upm0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (f_upm1) exp_q.push_back(p);
        exp_q.push_back(1'b1);
        if (f_usbs) exp_q.push_back(1'b1);
    endtask

    task automatic set_fmt(input logic [2:0] u, input logic p1, input logic p0, input logic s);
        ucsz = u; upm1 = p1; upm0 = p0; usbs = s;
    endtask

    initial begin
        logic b;
        int   n;

        tbl[0] = '{3'b011, 1'b0, 1'b0, 1'b0, 9'h0A5, 10, 12'b0101001011};
        tbl[1] = '{3'b010, 1'b1, 1'b0, 1'b1, 9'h041, 11, 12'b01000001011};
        tbl[2] = '{3'b111, 1'b1, 1'b1, 1'b0, 9'h1FF, 12, 12'b011111111101};
        tbl[3] = '{3'b000, 1'b0, 1'b0, 1'b1, 9'h013, 8,  12'b01100111};
        tbl[4] = '{3'b001, 1'b1, 1'b1, 1'b0, 9'h02A, 9,  12'b001010101};
        tbl[5] = '{3'b100, 1'b0, 1'b0, 1'b0, 9'h1F0, 10, 12'b0000011111};

        rst = 1'b1; txclk = 1'b0; txen = 1'b0; udre = 1'b1; txc_clr = 1'b0;
        set_fmt(3'b011, 1'b0, 1'b0, 1'b0);
`ifdef USART_TX_BREAK_EN
        brk = 1'b0;
`endif
        udr = '0; shreg = '0; par = 1'b0; txd = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_txc", txc, 0);
        check("reset_busy", busy, 0);
        check("reset_we", we, 0);
        check("reset_ps", ps, 1);
        check("reset_ad", ad, 0);
        check("reset_pi", pi, 1);
        check("reset_dp", dp, 0);

        txen = 1'b1;
        tick(1'b0);
        check("idle_txd", txd, 1);

        for (int v = 0; v < 6; v++) begin
            set_fmt(tbl[v].ucsz, tbl[v].upm1, tbl[v].upm0, tbl[v].usbs);
            write_udr(tbl[v].data);
            we_cnt = 0;
            for (int k = 0; k < tbl[v].len; k++) begin
                tick(1'b0);
                check($sformatf("vec%0d_bit%0d", v, k), txd, tbl[v].bits[tbl[v].len - 1 - k]);
                if (k < tbl[v].len - 1) check($sformatf("vec%0d_busy%0d", v, k), busy, 1);
            end
            check($sformatf("vec%0d_txc", v), txc, 1);
            check($sformatf("vec%0d_idle_busy", v), busy, 0);
            check($sformatf("vec%0d_we_count", v), we_cnt, 1);
            tick(1'b0);
            check($sformatf("vec%0d_after", v), txd, 1);
        end

        // Back-to-back: second write during the first frame.
        set_fmt(3'b011, 1'b0, 1'b0, 1'b0);
        push_frame(3'b011, 1'b0, 1'b0, 1'b0, 9'h05A);
        push_frame(3'b011, 1'b0, 1'b0, 1'b0, 9'h03C);
        write_udr(9'h05A);
        we_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0);
            if (k == 1) write_udr(9'h03C);
            b = exp_q.pop_front();
            check($sformatf("b2b_bit%0d", k), txd, b);
            if (k == 9) check("b2b_txc_mid", txc, 0);
            if (k == 10) check("b2b_busy_mid", busy, 1);
        end
        check("b2b_txc_end", txc, 1);
        check("b2b_we_count", we_cnt, 2);

        // Reset during data bit 3.
        write_udr(9'h0FF);
        repeat (4) tick(1'b0);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_txc", txc, 0);
        check("rst_ad", ad, 0);
        tick(1'b0);
        check("rst_line", txd, 1);

        // Frame end coincident with TXC clear: set wins.
        write_udr(9'h033);
        for (int k = 0; k < 9; k++) tick(1'b0);
        check("clr_txc_before", txc, 0);
        tick(1'b1);
        check("clr_same_cycle", txc, 1);
        txc_clr = 1'b1;
        @(posedge clk); #1;
        txc_clr = 1'b0;
        check("clr_alone", txc, 0);

        // TXEN dropped mid-frame: frame finishes, pending data not loaded.
        write_udr(9'h0C3);
        we_cnt = 0;
        repeat (3) tick(1'b0);
        txen = 1'b0;
        write_udr(9'h011);
        repeat (7) tick(1'b0);
        check("txen_off_busy", busy, 0);
        check("txen_off_txc", txc, 0);
        repeat (2) tick(1'b0);
        check("txen_off_line", txd, 1);
        check("txen_off_we", we_cnt, 1);
        txen = 1'b1;
        repeat (10) tick(1'b0);
        check("txen_on_txc", txc, 1);

`ifdef USART_TX_BREAK_EN
        brk = 1'b1;
        write_udr(9'h055);
        we_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            tick(1'b0);
            check($sformatf("brk_low%0d", k), txd, 0);
        end
        check("brk_busy", busy, 1);
        check("brk_we", we_cnt, 0);
        brk = 1'b0;
        tick(1'b0);
        check("brk_release", txd, 1);
        check("brk_release_we", we_cnt, 0);
        tick(1'b0);
        check("brk_start", txd, 0);
        check("brk_start_we", we_cnt, 1);
        repeat (9) tick(1'b0);
        check("brk_frame_txc", txc, 1);
`endif

        // Random frames; format inputs are scrambled mid-frame.
        for (int f = 0; f < 30; f++) begin
            logic [2:0] r_ucsz;
            logic       r_p1, r_p0, r_s;
            logic [8:0] r_d;
            r_ucsz = 3'($urandom_range(0, 7));
            r_p1   = 1'($urandom_range(0, 1));
            r_p0   = 1'($urandom_range(0, 1));
            r_s    = 1'($urandom_range(0, 1));
            r_d    = 9'($urandom);
            set_fmt(r_ucsz, r_p1, r_p0, r_s);
            push_frame(r_ucsz, r_p1, r_p0, r_s, r_d);
            write_udr(r_d);
            n = 0;
            while (exp_q.size() > 0 && n < 16) begin
                tick(1'b0);
                if (n == 0) begin
                    ucsz = 3'($urandom);
                    upm1 = 1'($urandom);
                    usbs = 1'($urandom);
                end
                b = exp_q.pop_front();
                check($sformatf("rnd%0d_bit%0d", f, n), txd, b);
                n++;
            end
            check($sformatf("rnd%0d_len", f), exp_q.size(), 0);
            exp_q.delete();
            check($sformatf("rnd%0d_txc", f), txc, 1);
            check($sformatf("rnd%0d_busy", f), busy, 0);
            repeat ($urandom_range(0, 2)) tick(1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_frame_controller.md
Name: tx_frame_controller

Overview:
- Transmit sequencer for the USART data path transmitter.
- Generates the per-bit control strobes (we, ps, ad, pi, dp) that the data path samples on each i_txclk enable. This produces start, 5–9 data, optional parity, and 1–2 stop bits per frame.
- Maintains the transmit-complete (TXC) flag and a busy indication.
- Sits between the UCSR control registers and the transmit data path; one instance per USART.

Parameters:
- BITCNT_W, 4, width of the data-bit counter; must hold the value 9.

Ports:
- i_fosk, input, 1, system clock.
- i_rst, input, 1, reset, synchronous, active-high.
- i_txclk, input, 1, transmitter bit-rate clock enable, one i_fosk cycle wide.
- i_TXEN, input, 1, transmitter enable.
- i_udre, input, 1, UDRE flag from the data path; 0 = data waiting in UDR.
- i_UCSZ, input, 3, character size code.
- i_UPM1, input, 1, parity enable.
- i_USBS, input, 1, stop bit select: 0 = one stop bit, 1 = two.
- i_txc_clr, input, 1, clear TXC (write-one, single i_fosk cycle).
- o_fsm_we, output, 1, load UDR into shift register.
- o_fsm_ps, output, 1, start/stop/idle level.
- o_fsm_ad, output, 1, 1 = send data bit.
- o_fsm_pi, output, 1, parity initialise.
- o_fsm_dp, output, 1, 1 = send parity bit.
- o_txc, output, 1, transmit-complete flag.
- o_busy, output, 1, frame in progress.

Behaviour:
- All state changes happen on posedge i_fosk, and only in cycles with i_txclk=1, except reset and TXC clear.
- i_rst=1 forces, on the next edge:
  - state IDLE, bit counter 0, o_txc=0, o_busy=0.
  - Idle strobe values: ad=0, ps=1, pi=1, dp=0.
  - o_fsm_we=0 whenever i_udre=1.
- States: IDLE, DATA, PARITY, STOP1, STOP2.
- Strobes are Moore decodes of state, except we and ps in IDLE.
- Line timing: the data path registers TxD on the tick, so each bit appears on TxD for one i_txclk period after the tick that selects it.
- IDLE:
  - ad=0, dp=0, pi=1.
  - start = i_TXEN & ~i_udre.
  - o_fsm_we = start; o_fsm_ps = ~start (0 emits the start bit in the same tick as the load).
  - On a tick with start=1:
    - latch the frame format: char size, parity enable, stop bits.
    - bit counter ← 0, clear o_txc, go to DATA.
  - Ticks with start=0 keep the line at 1.
- Character size (latched at load): UCSZ 000=5, 001=6, 010=7, 011=8, 111=9 bits; 100/101/110 treated as 8.
- Changing UCSZ, UPM1 or USBS mid-frame has no effect until the next load.
- DATA:
  - ad=1, pi=0, dp=0, ps=1, we=0.
  - Each tick increments the counter.
  - On the tick where counter = size−1: go to PARITY if parity is enabled, else STOP1.
- PARITY: dp=1, ad=0, pi=0, ps=1; one tick, then STOP1.
- STOP1: ad=0, ps=1, dp=0, pi=1; one tick, then STOP2 if USBS=1, else end-of-frame.
- STOP2: same strobes as STOP1; one tick, then end-of-frame.
- End-of-frame: go to IDLE on that tick.
  - If i_udre=1 at that tick, set o_txc on the same edge.
  - If i_udre=0, o_txc is not set, and the next frame starts on the following tick (back-to-back, no extra idle bit).
- o_txc:
  - Sticky; cleared by i_txc_clr=1 or by a load.
  - If set and clear occur in the same cycle, set wins.
- o_busy = (state ≠ IDLE), registered.
- i_TXEN deasserted mid-frame: the current frame completes normally, and no new load follows.
- Reset mid-frame: frame is abandoned and the line returns to idle (1) on the next tick.

Optional Feature:
- Macro: USART_TX_BREAK_EN.
- Defined:
  - adds input i_brk (1 bit).
  - While in IDLE with i_brk=1: o_fsm_we=0 and o_fsm_ps=0, so the line is held low (break).
  - Loads are inhibited and o_busy=1.
  - i_brk asserted mid-frame takes effect only after the frame ends.
  - Releasing i_brk returns the line to 1 on the next tick; a pending load may start no earlier than the following tick.
- Undefined: no i_brk port; IDLE behaviour as above.

Test Plan:
- 8N1 (UCSZ=011, UPM1=0, USBS=0), UDR=0xA5 written, TXEN=1 → TxD over 10 ticks: 0,1,0,1,0,0,1,0,1,1; o_fsm_we high for exactly one tick; o_txc=1 after the stop tick; o_busy low afterward.
- 7E2 (UCSZ=010, UPM1=1, UPM0=0, USBS=1), UDR=0x41 → TxD: 0,1,0,0,0,0,0,1,0,1,1; parity bit = 0 (two ones).
- 9O1 (UCSZ=111, UPM0=1), {tx8,tx}=0x1FF → 9 data bits of 1, parity=0, stop=1; total 12 ticks.
- Back-to-back: second UDR write during the first frame → stop bit followed immediately by a start bit on the next tick; o_txc stays 0 until the second frame ends.
- Reset and TXC: assert i_rst during data bit 3 → next tick TxD=1, o_busy=0, o_txc=0. Then the txc-clear case: i_txc_clr in the same cycle as the TXC set → o_txc=1.
- Break (USART_TX_BREAK_EN): i_brk=1 while idle → TxD=0 for every tick, with i_udre=0 not consumed (o_fsm_we=0). Release i_brk → TxD=1 for one tick, then the frame starts.
